i4201_clkgen: RTL

- Two-phase MCS-4 clock and power-on-clear generator, modelled on the i4201 role.
- Derives non-overlapping clk1/clk2 and poc from sysclk.
- Feeds clk1_pad/clk2_pad/poc_pad of the i4004 and every i4001/i4002 in the system, which recover phase from these signals in the sysclk domain.
- Also supplies sysclk-domain strobes so local logic can avoid edge detection.

---
 rtl/i4201_clkgen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/i4201_clkgen.sv
// i4201_clkgen: two-phase MCS-4 clock (clk1/clk2) and power-on-clear generator.
// One period is CLK1_WIDTH + GAP_12 + CLK2_WIDTH + GAP_21 sysclk cycles, and the
// phases never overlap. Every output is registered from the decode of the next
// position, so the outputs are glitch-free. The sysclk-domain strobes
// period_start and clk2_fall let local logic avoid edge detection.
// Optional feature macro: CLKGEN_STEP_EN (halt / single-step between periods).
module i4201_clkgen #(
  parameter int CLK1_WIDTH  = 8,
  parameter int GAP_12      = 4,
  parameter int CLK2_WIDTH  = 8,
  parameter int GAP_21      = 4,
  parameter int POC_PERIODS = 64
) (
  input  logic sysclk,
  input  logic sysreset,
  input  logic poc_req,
  input  logic halt,
  input  logic step,
  output logic clk1,
  output logic clk2,
  output logic poc,
  output logic period_start,
  output logic clk2_fall,
  output logic halted
);

  localparam int P     = CLK1_WIDTH + GAP_12 + CLK2_WIDTH + GAP_21;
  localparam int PW    = $clog2(P);
  localparam int CW    = $clog2(POC_PERIODS + 1);
  localparam int C2_LO = CLK1_WIDTH + GAP_12;
  localparam int C2_HI = C2_LO + CLK2_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(P - 1);

  if (CLK1_WIDTH < 1 || GAP_12 < 1 || CLK2_WIDTH < 1 || GAP_21 < 1 || POC_PERIODS < 1) begin : g_param_error
    $error("i4201_clkgen: every width, gap and POC_PERIODS must be >= 1");
  end

  logic [PW-1:0] pos;
  logic [PW-1:0] next_pos;
  logic [CW-1:0] cnt;
  logic          started;
  logic          req_s1;
  logic          req_s2;
  logic          hold;
  logic          wrap;
  logic          clk1_nxt;
  logic          clk2_nxt;

`ifdef CLKGEN_STEP_EN
  logic halt_s1;
  logic halt_s2;
  logic step_s1;
  logic step_s2;
  logic step_d;
  logic step_rise;

  // Two-FF synchronizers for halt and step, plus the previous synced step for its rising edge
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      halt_s1 <= 1'b0;
      halt_s2 <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      halt_s1 <= halt;
      halt_s2 <= halt_s1;
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_d;
  // Freeze only at the end of a period; a fresh step while frozen lets one period through
  assign hold = halt_s2 & (pos == LAST) & ~(halted & step_rise);
`else
  logic unused_step_inputs;
  assign unused_step_inputs = halt ^ step;
  assign hold = 1'b0;
`endif

  // Next position and phase decode; the first edge out of reset is not a completed period
  always_comb begin
    next_pos = pos;
    if (hold) begin
      next_pos = LAST;
    end else if (pos == LAST) begin
      next_pos = '0;
    end else begin
      next_pos = pos + PW'(1);
    end
    wrap     = started & (pos == LAST) & ~hold;
    clk1_nxt = int'(next_pos) < CLK1_WIDTH;
    clk2_nxt = (int'(next_pos) >= C2_LO) && (int'(next_pos) < C2_HI);
  end

  // Position counter and registered clock/strobe outputs
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      pos          <= LAST;
      started      <= 1'b0;
      clk1         <= 1'b0;
      clk2         <= 1'b0;
      period_start <= 1'b0;
      clk2_fall    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      pos          <= next_pos;
      started      <= 1'b1;
      clk1         <= clk1_nxt;
      clk2         <= clk2_nxt;
      period_start <= (next_pos == '0);
      clk2_fall    <= clk2 & ~clk2_nxt;
      halted       <= hold;
    end
  end

  // poc_req synchronizer
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
    end else begin
      req_s1 <= poc_req;
      req_s2 <= req_s1;
    end
  end

  // Power-on clear: held by a synced request, released on the wrap that completes POC_PERIODS
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      cnt <= '0;
      poc <= 1'b1;
    end else if (req_s2) begin
      cnt <= '0;
      poc <= 1'b1;
    end else if (wrap && poc) begin
      if (int'(cnt) < POC_PERIODS) begin
        cnt <= cnt + CW'(1);
      end
      if (int'(cnt) + 1 >= POC_PERIODS) begin
        poc <= 1'b0;
      end
    end
  end

endmodule
